// File: rtl/quad_enc_gen.sv
// Quadrature encoder signal generator: emits a commanded number of Gray-code
// edges on QA/QB and tracks a signed edge position. Optional macro QENC_BOUNCE_EN
// turns every edge into a new/old/new contact-bounce triplet.
module quad_enc_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned POS_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             DIR,
  input  logic [CNT_W-1:0] STEPS,
  input  logic [DIV_W-1:0] PERIOD,
  input  logic             ABORT,
  output logic             QA,
  output logic             QB,
  output logic             BUSY,
  output logic             DONE,
  output logic [POS_W-1:0] POS
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_phase, w_phase;
  logic [1:0]       r_q,     w_q;
  logic [POS_W-1:0] r_pos,   w_pos;
  logic [DIV_W-1:0] r_timer, w_timer;
  logic [DIV_W-1:0] r_period, w_period;
  logic [CNT_W-1:0] r_rem,   w_rem;
  logic             r_dir,   w_dir;
  logic             r_done,  w_done;

  logic [DIV_W-1:0] w_peff;
  logic [1:0]       w_phase_adv;
  logic [POS_W-1:0] w_pos_adv;

`ifdef QENC_BOUNCE_EN
  logic [1:0]       r_bcnt,  w_bcnt;
  logic             r_abort_pend, w_abort_pend;
`endif

  // Phase index to {QA,QB}: 0=11, 1=01, 2=00, 3=10.
  function automatic logic [1:0] f_enc(input logic [1:0] idx);
    logic [1:0] v;
    case (idx)
      2'd0:    v = 2'b11;
      2'd1:    v = 2'b01;
      2'd2:    v = 2'b00;
      default: v = 2'b10;
    endcase
    return v;
  endfunction

  always_comb begin
`ifdef QENC_BOUNCE_EN
    w_peff = (PERIOD < DIV_W'(3)) ? DIV_W'(3) : PERIOD;
`else
    w_peff = (PERIOD == '0) ? DIV_W'(1) : PERIOD;
`endif
    w_phase_adv = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);
    w_pos_adv   = r_dir ? (r_pos - POS_W'(1)) : (r_pos + POS_W'(1));
  end

  always_comb begin
    w_state  = r_state;
    w_phase  = r_phase;
    w_q      = r_q;
    w_pos    = r_pos;
    w_timer  = r_timer;
    w_period = r_period;
    w_rem    = r_rem;
    w_dir    = r_dir;
    w_done   = 1'b0;
`ifdef QENC_BOUNCE_EN
    w_bcnt       = r_bcnt;
    w_abort_pend = r_abort_pend;
`endif
    case (r_state)
      S_IDLE: begin
        if (START) begin
          if (STEPS != '0) begin
            w_dir    = DIR;
            w_period = w_peff;
            w_timer  = w_peff - DIV_W'(1);
            w_rem    = STEPS;
            w_state  = S_RUN;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      S_RUN: begin
`ifdef QENC_BOUNCE_EN
        // Timer is reloaded at the triplet start and keeps counting through
        // it, so nominal edge spacing stays at the latched period.
        case (r_bcnt)
          2'd0: begin
            if (ABORT) begin
              w_state = S_IDLE;
            end else if (r_timer != '0) begin
              w_timer = r_timer - DIV_W'(1);
            end else begin
              w_q     = f_enc(w_phase_adv);
              w_timer = r_period - DIV_W'(1);
              w_bcnt  = 2'd1;
            end
          end
          2'd1: begin
            w_q          = f_enc(r_phase);
            w_timer      = r_timer - DIV_W'(1);
            w_bcnt       = 2'd2;
            w_abort_pend = r_abort_pend | ABORT;
          end
          default: begin
            w_q          = f_enc(w_phase_adv);
            w_phase      = w_phase_adv;
            w_pos        = w_pos_adv;
            w_rem        = r_rem - CNT_W'(1);
            w_timer      = r_timer - DIV_W'(1);
            w_bcnt       = 2'd0;
            w_abort_pend = 1'b0;
            if (r_rem == CNT_W'(1)) begin
              w_state = S_IDLE;
              w_done  = 1'b1;
            end else if (r_abort_pend || ABORT) begin
              w_state = S_IDLE;
            end
          end
        endcase
`else
        if (ABORT) begin
          w_state = S_IDLE;
        end else if (r_timer != '0) begin
          w_timer = r_timer - DIV_W'(1);
        end else begin
          w_phase = w_phase_adv;
          w_q     = f_enc(w_phase_adv);
          w_pos   = w_pos_adv;
          w_rem   = r_rem - CNT_W'(1);
          w_timer = r_period - DIV_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
          end
        end
`endif
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_phase  <= 2'd0;
      r_q      <= 2'b11;
      r_pos    <= '0;
      r_timer  <= '0;
      r_period <= '0;
      r_rem    <= '0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
`ifdef QENC_BOUNCE_EN
      r_bcnt       <= 2'd0;
      r_abort_pend <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_phase  <= w_phase;
      r_q      <= w_q;
      r_pos    <= w_pos;
      r_timer  <= w_timer;
      r_period <= w_period;
      r_rem    <= w_rem;
      r_dir    <= w_dir;
      r_done   <= w_done;
`ifdef QENC_BOUNCE_EN
      r_bcnt       <= w_bcnt;
      r_abort_pend <= w_abort_pend;
`endif
    end
  end

  assign QA   = r_q[1];
  assign QB   = r_q[0];
  assign BUSY = (r_state == S_RUN);
  assign DONE = r_done;
  assign POS  = r_pos;

endmodule

// File: tb/tb_quad_enc_gen.sv
// Bench for quad_enc_gen (default build): directed steps plus random commands,
// checked every cycle against a schedule-based edge model.
module tb_quad_enc_gen;

  logic        CLK = 1'b0;
  logic        RST, START, DIR, ABORT;
  logic [15:0] STEPS, PERIOD;
  logic        QA, QB, BUSY, DONE;
  logic [15:0] POS;

  quad_enc_gen #(.CNT_W(16), .DIV_W(16), .POS_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIR(DIR), .STEPS(STEPS),
    .PERIOD(PERIOD), .ABORT(ABORT), .QA(QA), .QB(QB), .BUSY(BUSY),
    .DONE(DONE), .POS(POS)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: edges are due at t0 + k*peff after an accepted start.
  logic [1:0] enc_tab [4];
  int  cyc, m_t0, m_peff, m_steps, m_k, m_phase, m_pos;
  bit  m_busy, m_dir, m_done;
  int  n_done, n_edges;
  logic [1:0] prev_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (RST) begin
      m_busy = 0; m_phase = 0; m_pos = 0;
    end else if (!m_busy) begin
      if (START) begin
        if (STEPS != 0) begin
          m_busy = 1; m_t0 = cyc; m_k = 0; m_dir = DIR; m_steps = STEPS;
          m_peff = (PERIOD == 0) ? 1 : int'(PERIOD);
        end else begin
          m_done = 1'b1;
        end
      end
    end else if (ABORT) begin
      m_busy = 0;
    end else if (cyc == m_t0 + (m_k + 1) * m_peff) begin
      m_k++;
      m_phase = (m_phase + (m_dir ? 3 : 1)) % 4;
      m_pos   = m_pos + (m_dir ? -1 : 1);
      if (m_k == m_steps) begin
        m_busy = 0; m_done = 1'b1;
      end
    end
  endtask

  task automatic tick();
    logic [1:0] q_exp;
    logic [15:0] pos_exp;
    @(posedge CLK);
    cyc++;
    model_edge();
    #1;
    q_exp   = enc_tab[m_phase];
    pos_exp = m_pos[15:0];
    chk("QA", QA, q_exp[1]);
    chk("QB", QB, q_exp[0]);
    chk("BUSY", BUSY, m_busy);
    chk("DONE", DONE, m_done);
    chk("POS", POS, pos_exp);
    if (DONE) n_done++;
    if ({QA, QB} != prev_q) n_edges++;
    prev_q = {QA, QB};
    START = 1'b0; ABORT = 1'b0; RST = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    for (int i = 0; i < budget && m_busy; i++) tick();
    chk(tag, BUSY, 1'b0);
  endtask

  task automatic cmd(input bit d, input int s, input int p);
    START = 1'b1; DIR = d; STEPS = 16'(s); PERIOD = 16'(p);
    tick();
  endtask

  initial begin
    int pos_before;
    enc_tab[0] = 2'b11; enc_tab[1] = 2'b01; enc_tab[2] = 2'b00; enc_tab[3] = 2'b10;
    cyc = 0; m_busy = 0; m_phase = 0; m_pos = 0; m_done = 0; m_dir = 0;
    m_t0 = 0; m_peff = 1; m_steps = 0; m_k = 0; n_done = 0; n_edges = 0;
    prev_q = 2'b11;
    RST = 1'b1; START = 1'b0; DIR = 1'b0; ABORT = 1'b0; STEPS = '0; PERIOD = '0;

    // Reset
    @(posedge CLK); RST = 1'b1; tick(); RST = 1'b1; tick();
    chk("rst_qaqb", {QA, QB}, 2'b11);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_pos", POS, 16'd0);
    tick();

    // Forward 5 edges, period 4
    n_done = 0; n_edges = 0;
    cmd(1'b0, 5, 4);
    run_until_idle(40, "fwd_timeout");
    tick();
    chk("fwd_pos", POS, 16'd5);
    chk("fwd_qaqb", {QA, QB}, 2'b01);
    chk("fwd_ndone", n_done, 1);
    chk("fwd_nedges", n_edges, 5);

    // Reverse 3 edges, period 0 (treated as 1)
    cmd(1'b1, 3, 0);
    run_until_idle(10, "rev_timeout");
    chk("rev_pos", POS, 16'd2);
    chk("rev_qaqb", {QA, QB}, 2'b00);

    // STEPS=0: DONE next cycle, no edge
    n_edges = 0;
    cmd(1'b0, 0, 3);
    chk("zero_done", DONE, 1'b1);
    tick();
    chk("zero_nedges", n_edges, 0);

    // START during BUSY is ignored
    n_edges = 0;
    cmd(1'b0, 2, 3);
    for (int i = 0; i < 4; i++) begin
      START = 1'b1; DIR = 1'b1; STEPS = 16'd7; PERIOD = 16'd1;
      tick();
    end
    run_until_idle(20, "busy_timeout");
    tick();
    chk("busy_nedges", n_edges, 2);
    chk("busy_pos", POS, 16'd4);

    // ABORT after 2 of 10 edges
    n_done = 0;
    pos_before = m_pos;
    cmd(1'b0, 10, 2);
    for (int i = 0; i < 20 && m_k < 2; i++) tick();
    ABORT = 1'b1; tick();
    chk("abort_busy", BUSY, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("abort_ndone", n_done, 0);
    chk("abort_pos", POS, 16'(pos_before + 2));

    // RST mid-run
    cmd(1'b1, 8, 2);
    for (int i = 0; i < 5; i++) tick();
    RST = 1'b1; tick();
    chk("rstmid_qaqb", {QA, QB}, 2'b11);
    chk("rstmid_pos", POS, 16'd0);
    chk("rstmid_busy", BUSY, 1'b0);

    // Random commands, aborts, overlapping and back-to-back starts
    for (int i = 0; i < 1500; i++) begin
      START  = ($urandom_range(0, 3) == 0);
      DIR    = $urandom_range(0, 1);
      STEPS  = 16'($urandom_range(0, 6));
      PERIOD = 16'($urandom_range(0, 4));
      ABORT  = ($urandom_range(0, 40) == 0);
      tick();
    end
    // Reverse past zero to exercise negative / wrapped positions
    cmd(1'b1, 40, 1);
    run_until_idle(60, "wrap_timeout");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
